// File: rtl/motor_spi_master.sv
// SPI mode-0 master that sends one two-byte signed-magnitude motor command frame
// (motor1 then motor2) framed by load, and captures the 16 bits the slave returns.
module motor_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [6:0]  MAX_MAG = 7'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  motor1,
    input  logic [7:0]  motor2,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    // Limit the magnitude field while keeping the sign bit untouched.
    function automatic logic [7:0] clamp_byte(input logic [7:0] cmd);
        logic [6:0] mag;
        if (cmd[6:0] > MAX_MAG) begin
            mag = MAX_MAG;
        end else begin
            mag = cmd[6:0];
        end
        return {cmd[7], mag};
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  div_r, div_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic [15:0] tx_shift_r, tx_shift_s;
    logic [15:0] rx_shift_r, rx_shift_s;
    logic [15:0] rx_data_r, rx_data_s;
    logic        sck_r, sck_s;
    logic        load_r, load_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [15:0] frame_s;
    logic        phase_end_s;

    assign frame_s     = {clamp_byte(motor1), clamp_byte(motor2)};
    assign phase_end_s = (div_r == DIV_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        bit_cnt_s  = bit_cnt_r;
        tx_shift_s = tx_shift_r;
        rx_shift_s = rx_shift_r;
        rx_data_s  = rx_data_r;
        sck_s      = sck_r;
        load_s     = load_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        case (state_r)
            IDLE: begin
                div_s = 8'd0;
                if (start) begin
                    state_s    = LEAD;
                    tx_shift_s = frame_s;
                    bit_cnt_s  = 4'd0;
                    sck_s      = 1'b0;
                    load_s     = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LEAD, LOW: begin
                if (phase_end_s) begin
                    state_s    = HIGH;
                    div_s      = 8'd0;
                    sck_s      = 1'b1;
                    rx_shift_s = {rx_shift_r[14:0], miso};
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            HIGH: begin
                if (phase_end_s) begin
                    div_s = 8'd0;
                    sck_s = 1'b0;
                    if (bit_cnt_r == 4'd15) begin
                        state_s = TRAIL;
                    end else begin
                        // mosi is the MSB of the shifter, so it only moves while sck is low
                        state_s    = LOW;
                        tx_shift_s = {tx_shift_r[14:0], 1'b0};
                        bit_cnt_s  = bit_cnt_r + 4'd1;
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            TRAIL: begin
                if (phase_end_s) begin
                    state_s   = DONE;
                    div_s     = 8'd0;
                    load_s    = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    rx_data_s = rx_shift_r;
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                div_s   = 8'd0;
            end
            default: begin
                state_s = IDLE;
                div_s   = 8'd0;
                sck_s   = 1'b0;
                load_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            div_r      <= 8'd0;
            bit_cnt_r  <= 4'd0;
            tx_shift_r <= 16'd0;
            rx_shift_r <= 16'd0;
            rx_data_r  <= 16'd0;
            sck_r      <= 1'b0;
            load_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            bit_cnt_r  <= bit_cnt_s;
            tx_shift_r <= tx_shift_s;
            rx_shift_r <= rx_shift_s;
            rx_data_r  <= rx_data_s;
            sck_r      <= sck_s;
            load_r     <= load_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign sck     = sck_r;
    assign mosi    = tx_shift_r[15];
    assign load    = load_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule

// File: tb/tb_motor_spi_master.sv
// Directed bench for motor_spi_master: a CLK_DIV=4 and a CLK_DIV=1 instance,
// observed through one negedge monitor that also plays a mode-0 echo slave.
module tb_motor_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  motor1 = 8'h00;
    logic [7:0]  motor2 = 8'h00;
    logic        miso = 1'b0;

    logic        sck4, mosi4, load4, busy4, done4;
    logic [15:0] rx4;
    logic        sck1, mosi1, load1, busy1, done1;
    logic [15:0] rx1;

    always #5 clk = ~clk;

    motor_spi_master #(.CLK_DIV(4), .MAX_MAG(7'd100)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .motor1(motor1), .motor2(motor2),
        .miso(miso), .sck(sck4), .mosi(mosi4), .load(load4), .busy(busy4),
        .done(done4), .rx_data(rx4)
    );

    motor_spi_master #(.CLK_DIV(1), .MAX_MAG(7'd100)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .motor1(motor1), .motor2(motor2),
        .miso(miso), .sck(sck1), .mosi(mosi1), .load(load1), .busy(busy1),
        .done(done1), .rx_data(rx1)
    );

    logic        sel = 1'b0;
    logic        sck_m, mosi_m, load_m, busy_m, done_m;
    logic [15:0] rx_m;
    assign sck_m  = sel ? sck1  : sck4;
    assign mosi_m = sel ? mosi1 : mosi4;
    assign load_m = sel ? load1 : load4;
    assign busy_m = sel ? busy1 : busy4;
    assign done_m = sel ? done1 : done4;
    assign rx_m   = sel ? rx1   : rx4;

    logic [15:0] slave_pat = 16'h0000;
    logic [15:0] tx_bits = 16'h0000;
    logic        prev_sck = 1'b0;
    logic        prev_load = 1'b0;
    logic        prev_mosi = 1'b0;
    int rise_cnt = 0, load_cycles = 0, done_cnt = 0, low_run = 0, last_gap = 0;
    int mosi_viol = 0, cyc = 0, last_rise_cyc = -1, per_min = 1000, per_max = 0, period = 0;
    int n_assert = 0, n_fail = 0;
    int d0 = 0;

    // Frame monitor and echo slave: presents the next pattern bit while sck is low.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (load_m && !prev_load) begin
            last_gap      = low_run;
            rise_cnt      = 0;
            tx_bits       = 16'h0000;
            load_cycles   = 0;
            per_min       = 1000;
            per_max       = 0;
            last_rise_cyc = -1;
            miso          = slave_pat[15];
        end
        if (load_m) begin
            load_cycles = load_cycles + 1;
            low_run     = 0;
        end else begin
            low_run = low_run + 1;
        end
        if (sck_m && !prev_sck) begin
            tx_bits = {tx_bits[14:0], mosi_m};
            if (last_rise_cyc >= 0) begin
                period = cyc - last_rise_cyc;
                if (period < per_min) per_min = period;
                if (period > per_max) per_max = period;
            end
            last_rise_cyc = cyc;
            rise_cnt      = rise_cnt + 1;
            if (rise_cnt < 16) miso = slave_pat[15 - rise_cnt];
            else               miso = 1'b0;
        end
        if (sck_m && (mosi_m !== prev_mosi)) mosi_viol = mosi_viol + 1;
        if (done_m) done_cnt = done_cnt + 1;
        prev_sck  = sck_m;
        prev_load = load_m;
        prev_mosi = mosi_m;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n = n + 1;
        end while (!done_m && n < budget);
        chk("done_seen", {31'd0, done_m}, 32'd1);
    endtask

    task automatic pulse_start(input logic which1);
        if (which1) start1 = 1'b1; else start4 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        // Reset state, with start asserted to show reset dominates
        reset  = 1'b1;
        start4 = 1'b1;
        repeat (3) tick();
        chk("rst_sck",   {31'd0, sck4},  32'd0);
        chk("rst_mosi",  {31'd0, mosi4}, 32'd0);
        chk("rst_load",  {31'd0, load4}, 32'd0);
        chk("rst_busy",  {31'd0, busy4}, 32'd0);
        chk("rst_done",  {31'd0, done4}, 32'd0);
        chk("rst_rx",    {16'd0, rx4},   32'd0);
        chk("rst_load1", {31'd0, load1}, 32'd0);
        start4 = 1'b0;
        reset  = 1'b0;
        repeat (2) tick();

        // Basic frame
        motor1 = 8'h99; motor2 = 8'h32; slave_pat = 16'hA55A;
        d0 = done_cnt;
        pulse_start(1'b0);
        chk("basic_busy", {31'd0, busy_m}, 32'd1);
        wait_done(200);
        chk("basic_rx",    {16'd0, rx_m},    32'h0000A55A);
        chk("basic_tx",    {16'd0, tx_bits}, 32'h00009932);
        chk("basic_rises", rise_cnt,         32'd16);
        chk("basic_load",  load_cycles,      32'd132);
        chk("basic_pmin",  per_min,          32'd8);
        chk("basic_pmax",  per_max,          32'd8);
        chk("basic_dload", {31'd0, load_m},  32'd0);
        chk("basic_dbusy", {31'd0, busy_m},  32'd0);
        tick();
        chk("basic_done1cyc", {31'd0, done_m}, 32'd0);
        chk("basic_dcount", done_cnt - d0, 32'd1);

        // Clamp of both magnitudes
        motor1 = 8'h7F; motor2 = 8'hE5; slave_pat = 16'h3C0F;
        pulse_start(1'b0);
        wait_done(200);
        chk("clamp_tx", {16'd0, tx_bits}, 32'h000064E4);
        chk("clamp_rx", {16'd0, rx_m},    32'h00003C0F);

        // Start while busy, motor inputs changed mid-frame
        tick();
        motor1 = 8'h11; motor2 = 8'h22;
        d0 = done_cnt;
        pulse_start(1'b0);
        repeat (9) tick();
        motor1 = 8'h55; motor2 = 8'h66;
        pulse_start(1'b0);
        wait_done(200);
        chk("busy_tx", {16'd0, tx_bits}, 32'h00001122);
        repeat (40) tick();
        chk("busy_nosecond", done_cnt - d0, 32'd1);
        chk("busy_idle_load", {31'd0, load_m}, 32'd0);

        // Back-to-back frames with start held high
        motor1 = 8'h05; motor2 = 8'h85; slave_pat = 16'h5AA5;
        d0 = done_cnt;
        start4 = 1'b1;
        wait_done(200);
        wait_done(200);
        chk("b2b_gap2", last_gap, 32'd2);
        wait_done(200);
        start4 = 1'b0;
        chk("b2b_gap3", last_gap, 32'd2);
        chk("b2b_tx", {16'd0, tx_bits}, 32'h00000585);
        chk("b2b_rx", {16'd0, rx_m},    32'h00005AA5);
        chk("b2b_load", load_cycles,    32'd132);
        repeat (30) tick();
        chk("b2b_dcount", done_cnt - d0, 32'd3);
        chk("b2b_busy", {31'd0, busy_m}, 32'd0);

        // Reset mid-frame after the 7th sck rise
        motor1 = 8'h99; motor2 = 8'h32;
        pulse_start(1'b0);
        for (int i = 0; i < 200 && rise_cnt != 7; i++) tick();
        chk("abort_rises", rise_cnt, 32'd7);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        chk("abort_sck",  {31'd0, sck_m},  32'd0);
        chk("abort_load", {31'd0, load_m}, 32'd0);
        chk("abort_busy", {31'd0, busy_m}, 32'd0);
        chk("abort_done", {31'd0, done_m}, 32'd0);
        chk("abort_rx",   {16'd0, rx_m},   32'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("abort_nodone", done_cnt - d0, 32'd0);
        motor1 = 8'h2A; motor2 = 8'h81; slave_pat = 16'h1234;
        pulse_start(1'b0);
        wait_done(200);
        chk("after_tx",    {16'd0, tx_bits}, 32'h00002A81);
        chk("after_rx",    {16'd0, rx_m},    32'h00001234);
        chk("after_load",  load_cycles,      32'd132);
        chk("after_rises", rise_cnt,         32'd16);

        // CLK_DIV=1 instance
        sel = 1'b1;
        repeat (2) tick();
        motor1 = 8'h01; motor2 = 8'h80; slave_pat = 16'hC3A5;
        d0 = done_cnt;
        pulse_start(1'b1);
        wait_done(100);
        chk("div1_tx",    {16'd0, tx_bits}, 32'h00000180);
        chk("div1_rx",    {16'd0, rx_m},    32'h0000C3A5);
        chk("div1_load",  load_cycles,      32'd33);
        chk("div1_rises", rise_cnt,         32'd16);
        chk("div1_pmin",  per_min,          32'd2);
        chk("div1_pmax",  per_max,          32'd2);
        tick();
        chk("div1_dcount", done_cnt - d0, 32'd1);

        chk("mosi_stable", mosi_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
